// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with a one-entry response slot.
// Round-robin by default; define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 always wins).
module alu_arbiter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_in1,
    input  logic [XLEN-1:0] req0_in2,
    input  logic [3:0]      req0_funct,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_in1,
    input  logic [XLEN-1:0] req1_in2,
    input  logic [3:0]      req1_funct,

    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [3:0]      alu_funct,
    input  logic [XLEN-1:0] alu_result,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err
);

    localparam int unsigned FUNCT_W = 4;

    typedef struct packed {
        logic [XLEN-1:0]    in1;
        logic [XLEN-1:0]    in2;
        logic [FUNCT_W-1:0] funct;
    } alu_op_t;

    alu_op_t         op0_c;
    alu_op_t         op1_c;
    alu_op_t         op_sel_c;
    logic            slot_free_c;
    logic            grant0_c;
    logic            grant1_c;
    logic            grant_any_c;
    logic            illegal_c;
    logic [XLEN-1:0] result_c;

    assign op0_c = {req0_in1, req0_in2, req0_funct};
    assign op1_c = {req1_in1, req1_in2, req1_funct};

    // Slot accepts a new op when empty or being drained this cycle.
    assign slot_free_c = ~rsp_valid | rsp_ready;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n && slot_free_c) begin
            if (req0_valid) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end
`else
    logic last_grant;

    // Round-robin: on contention the requester not granted last wins.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n && slot_free_c) begin
            if (req0_valid && req1_valid) begin
                grant0_c = last_grant;
                grant1_c = ~last_grant;
            end else if (req0_valid) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    // Reset to 1 so req0 wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (grant_any_c) begin
            last_grant <= grant1_c;
        end
    end
`endif

    assign grant_any_c = grant0_c | grant1_c;
    assign req0_ready  = grant0_c;
    assign req1_ready  = grant1_c;

    // Operand mux toward the shared ALU; idle drives all-zero.
    always_comb begin
        op_sel_c = '0;
        if (grant1_c) begin
            op_sel_c = op1_c;
        end else if (grant0_c) begin
            op_sel_c = op0_c;
        end
    end

    assign alu_in1   = op_sel_c.in1;
    assign alu_in2   = op_sel_c.in2;
    assign alu_funct = op_sel_c.funct;

    always_comb begin
        illegal_c = 1'b0;
        case (op_sel_c.funct)
            4'b0010, 4'b0011, 4'b1010, 4'b1011: illegal_c = 1'b1;
            default:                            illegal_c = 1'b0;
        endcase
    end

    // Illegal codes never let the ALU's undefined output into the response.
    assign result_c = illegal_c ? '0 : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (grant_any_c) begin
            rsp_valid <= 1'b1;
            rsp_id    <= grant1_c;
            rsp_data  <= result_c;
            rsp_err   <= illegal_c;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed, table-driven bench for alu_arbiter with a reference ALU model on the shared ALU port.
module tb_alu_arbiter;

    localparam int unsigned XLEN = 32;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam bit RR = 1'b0;
`else
    localparam bit RR = 1'b1;
`endif

    logic            clk;
    logic            rst_n;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [XLEN-1:0] req0_in1, req0_in2, req1_in1, req1_in2;
    logic [3:0]      req0_funct, req1_funct;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_result;
    logic [3:0]      alu_funct;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [XLEN-1:0] rsp_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_funct(req1_funct),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_funct(alu_funct),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU; illegal codes return a marker that must never reach rsp_data.
    always_comb begin
        case (alu_funct)
            4'b0000: alu_result = alu_in1 + alu_in2;
            4'b1000: alu_result = alu_in1 - alu_in2;
            4'b0001: alu_result = alu_in1 << alu_in2[4:0];
            4'b0100: alu_result = alu_in1 ^ alu_in2;
            4'b0101: alu_result = alu_in1 >> alu_in2[4:0];
            4'b1101: alu_result = $signed(alu_in1) >>> alu_in2[4:0];
            4'b0110: alu_result = alu_in1 | alu_in2;
            4'b0111: alu_result = alu_in1 & alu_in2;
            default: alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic        v0;
        logic [31:0] a0, b0;
        logic [3:0]  f0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [3:0]  f1;
        logic        rr;
        logic        e_r0, e_r1;
        logic [3:0]  e_funct;
        logic        e_rv, e_id;
        logic [31:0] e_data;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] f0,
        input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] f1,
        input logic rr, input logic e_r0, input logic e_r1, input logic [3:0] e_funct,
        input logic e_rv, input logic e_id, input logic [31:0] e_data, input logic e_err);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.f0 = f0;
        v.v1 = v1; v.a1 = a1; v.b1 = b1; v.f1 = f1;
        v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_funct = e_funct;
        v.e_rv = e_rv; v.e_id = e_id; v.e_data = e_data; v.e_err = e_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive_idle();
        req0_valid = 1'b0; req0_in1 = '0; req0_in2 = '0; req0_funct = 4'b0000;
        req1_valid = 1'b0; req1_in1 = '0; req1_in2 = '0; req1_funct = 4'b0000;
    endtask

    vec_t vt[16];

    initial begin
        // Both-valid rows: req0 = 10-4 (SUB) = 6, req1 = 7<<2 (SLL) = 28.
        vt[0]  = mk(1'b1, 32'd5, 32'd3, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000,
                    1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 32'd8, 1'b0);
        vt[1]  = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'hF0, 32'hFF, 4'b0100,
                    1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 1'b1, 32'h0F, 1'b0);
        vt[2]  = mk(1'b1, 32'd10, 32'd4, 4'b1000, 1'b1, 32'd7, 32'd2, 4'b0001,
                    1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 32'd6, 1'b0);
        vt[3]  = mk(1'b1, 32'd10, 32'd4, 4'b1000, 1'b1, 32'd7, 32'd2, 4'b0001,
                    1'b1, !RR, RR, RR ? 4'b0001 : 4'b1000, 1'b1, RR, RR ? 32'd28 : 32'd6, 1'b0);
        vt[4]  = vt[2];
        vt[5]  = vt[3];
        // Slot full: req1 waits, response held.
        vt[6]  = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'h8000_0000, 32'd4, 4'b1101,
                    1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, RR, RR ? 32'd28 : 32'd6, 1'b0);
        vt[7]  = vt[6];
        vt[8]  = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'h8000_0000, 32'd4, 4'b1101,
                    1'b1, 1'b0, 1'b1, 4'b1101, 1'b1, 1'b1, 32'hF800_0000, 1'b0);
        vt[9]  = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b1, 32'd1, 32'd2, 4'b1010,
                    1'b1, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b1, 32'd0, 1'b1);
        vt[10] = vt[8];
        // Drain without new grant.
        vt[11] = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000,
                    1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'd0, 1'b0);
        vt[12] = mk(1'b1, 32'd9, 32'd9, 4'b0011, 1'b0, 32'd0, 32'd0, 4'b0000,
                    1'b1, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 32'd0, 1'b1);
        vt[13] = mk(1'b0, 32'd0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0, 4'b0000,
                    1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'd0, 1'b1);
        vt[14] = mk(1'b1, 32'hFF, 32'h0F, 4'b0111, 1'b1, 32'h8000_0000, 32'd4, 4'b0101,
                    1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'd0, 1'b1);
        vt[15] = mk(1'b1, 32'hFF, 32'h0F, 4'b0111, 1'b1, 32'h8000_0000, 32'd4, 4'b0101,
                    1'b1, !RR, RR, RR ? 4'b0101 : 4'b0111, 1'b1, RR,
                    RR ? 32'h0800_0000 : 32'h0000_000F, 1'b0);

        rst_n = 1'b0;
        drive_idle();
        rsp_ready = 1'b0;
        req0_valid = 1'b1;
        #3;
        check("reset req0_ready", 32'(req0_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_data", rsp_data, 32'd0);
        check("reset alu_funct", 32'(alu_funct), 32'd0);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            req0_valid = vt[i].v0; req0_in1 = vt[i].a0; req0_in2 = vt[i].b0; req0_funct = vt[i].f0;
            req1_valid = vt[i].v1; req1_in1 = vt[i].a1; req1_in2 = vt[i].b1; req1_funct = vt[i].f1;
            rsp_ready  = vt[i].rr;
            #2;
            check($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vt[i].e_r0));
            check($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vt[i].e_r1));
            check($sformatf("v%0d alu_funct", i), 32'(alu_funct), 32'(vt[i].e_funct));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_rv));
            if (vt[i].e_rv) begin
                check($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vt[i].e_id));
                check($sformatf("v%0d rsp_data", i), rsp_data, vt[i].e_data);
                check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vt[i].e_err));
            end
        end

        // Asynchronous reset while a response is held and both requesters wait.
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async rsp_valid", 32'(rsp_valid), 32'd0);
        check("async rsp_data", rsp_data, 32'd0);
        check("async rsp_id", 32'(rsp_id), 32'd0);
        check("async rsp_err", 32'(rsp_err), 32'd0);
        check("async req0_ready", 32'(req0_ready), 32'd0);
        check("async req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post-reset idle %0d rsp_valid", c), 32'(rsp_valid), 32'd0);
        end

        // First contention after reset goes to req0 in both builds.
        req0_valid = 1'b1; req0_in1 = 32'd100; req0_in2 = 32'd23; req0_funct = 4'b0000;
        req1_valid = 1'b1; req1_in1 = 32'd1;   req1_in2 = 32'd1;  req1_funct = 4'b0000;
        rsp_ready = 1'b1;
        #2;
        check("first contention req0_ready", 32'(req0_ready), 32'd1);
        check("first contention req1_ready", 32'(req1_ready), 32'd0);
        check("first contention alu_in1", alu_in1, 32'd100);
        @(posedge clk);
        #1;
        check("first contention rsp_valid", 32'(rsp_valid), 32'd1);
        check("first contention rsp_id", 32'(rsp_id), 32'd0);
        check("first contention rsp_data", rsp_data, 32'd123);
        drive_idle();
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
